// File: rtl/sfp_ctrl.sv
// Sequencer for the SFP accumulate/ReLU datapath: clear, stream psums, drain, write per output.
// Optional `SFP_CTRL_PERF_EN adds a busy-cycle counter on port perf_cycles.
module sfp_ctrl #(
    parameter int PAW = 11,
    parameter int OAW = 5,
    parameter int KW  = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [KW-1:0]  cfg_kij,
    input  logic [OAW-1:0] cfg_onij,
    input  logic           stall,
    output logic           busy,
    output logic           done,
    output logic           psum_rd_en,
    output logic [PAW-1:0] psum_rd_addr,
    output logic           acc_clr,
    output logic           acc_en,
    output logic           out_wr_en,
    output logic [OAW-1:0] out_wr_addr
`ifdef SFP_CTRL_PERF_EN
    ,
    output logic [31:0]    perf_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE, CLR, READ, FLUSH, DRAIN, WRITE, DONE
    } state_t;

    state_t         state, nxt_state, op_state;
    logic [KW-1:0]  kij_q, k, nxt_k;
    logic [OAW-1:0] onij_q, o, nxt_o;
    logic [PAW-1:0] addr, nxt_addr;
    logic           bubble, op_fire;

    assign psum_rd_addr = addr;
    assign out_wr_addr  = o;

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        nxt_state = state;
        nxt_k     = k;
        nxt_o     = o;
        nxt_addr  = addr;
        case (state)
            CLR:   nxt_state = READ;
            READ: begin
                if (k == kij_q - KW'(1)) begin
                    nxt_state = FLUSH;
                end else begin
                    nxt_k    = k + KW'(1);
                    nxt_addr = addr + PAW'(onij_q);
                end
            end
            FLUSH: nxt_state = DRAIN;
            DRAIN: nxt_state = WRITE;
            WRITE: begin
                if (o == onij_q - OAW'(1)) begin
                    nxt_state = DONE;
                end else begin
                    nxt_state = CLR;
                    nxt_o     = o + OAW'(1);
                    nxt_k     = '0;
                    nxt_addr  = PAW'(o + OAW'(1));
                end
            end
            default: nxt_state = state;
        endcase
    end

    // A stall seen at an edge turns the following cycle into a bubble: the pending
    // operation is parked in state and performed once stall drops.
    always_comb begin
        op_state = bubble ? state : nxt_state;
        op_fire  = !stall || (op_state == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            kij_q      <= '0;
            onij_q     <= '0;
            k          <= '0;
            o          <= '0;
            addr       <= '0;
            bubble     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            psum_rd_en <= 1'b0;
            acc_clr    <= 1'b0;
            acc_en     <= 1'b0;
            out_wr_en  <= 1'b0;
        end else begin
            acc_en <= psum_rd_en;
            case (state)
                IDLE: begin
                    bubble     <= 1'b0;
                    psum_rd_en <= 1'b0;
                    out_wr_en  <= 1'b0;
                    if (start) begin
                        kij_q  <= cfg_kij;
                        onij_q <= cfg_onij;
                        k      <= '0;
                        o      <= '0;
                        addr   <= '0;
                        if (cfg_kij != '0 && cfg_onij != '0) begin
                            state   <= CLR;
                            busy    <= 1'b1;
                            acc_clr <= 1'b1;
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            acc_clr <= 1'b0;
                        end
                    end else begin
                        acc_clr <= 1'b0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    bubble     <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    psum_rd_en <= 1'b0;
                    acc_clr    <= 1'b0;
                    out_wr_en  <= 1'b0;
                end
                default: begin
                    if (!bubble) begin
                        state <= nxt_state;
                        k     <= nxt_k;
                        o     <= nxt_o;
                        addr  <= nxt_addr;
                    end
                    bubble     <= !op_fire;
                    acc_clr    <= op_fire && (op_state == CLR);
                    psum_rd_en <= op_fire && (op_state == READ);
                    out_wr_en  <= op_fire && (op_state == WRITE);
                    done       <= (op_state == DONE);
                    busy       <= (op_state != DONE);
                end
            endcase
        end
    end

`ifdef SFP_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed self-checking bench for sfp_ctrl: nominal, minimal, stall, zero-cfg and reset passes.
module tb_sfp_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  cfg_kij;
    logic [4:0]  cfg_onij;
    logic        stall;
    logic        busy, done, psum_rd_en, acc_clr, acc_en, out_wr_en;
    logic [10:0] psum_rd_addr;
    logic [4:0]  out_wr_addr;
`ifdef SFP_CTRL_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_at_done;
`endif

    sfp_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_kij      (cfg_kij),
        .cfg_onij     (cfg_onij),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .psum_rd_en   (psum_rd_en),
        .psum_rd_addr (psum_rd_addr),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .out_wr_en    (out_wr_en),
        .out_wr_addr  (out_wr_addr)
`ifdef SFP_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int n_rd, n_acc, n_clr, n_wr, done_cyc;
    int err_lag, err_ovl, err_addr, err_wr;
    logic        log_rd   [300];
    logic        log_acc  [300];
    logic        log_clr  [300];
    logic        log_wr   [300];
    logic        log_done [300];
    logic        log_busy [300];
    logic [10:0] log_addr [300];
    logic [4:0]  log_waddr[300];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the start cycle; logs record outputs sampled mid-cycle at the falling edge.
    task automatic run_pass(input logic [3:0] kij_v, input logic [4:0] onij_v,
                            input int stall_from, input int stall_to,
                            input int extra_start, input int reset_at);
        int grp, rix;
        logic prev_rd;
        logic [10:0] exp_addr;
        n_rd = 0; n_acc = 0; n_clr = 0; n_wr = 0; done_cyc = -1;
        err_lag = 0; err_ovl = 0; err_addr = 0; err_wr = 0;
        grp = 0; rix = 0; prev_rd = 1'b0;
        for (int i = 0; i < 300; i++) begin
            log_rd[i] = 0; log_acc[i] = 0; log_clr[i] = 0; log_wr[i] = 0;
            log_done[i] = 0; log_busy[i] = 0; log_addr[i] = '0; log_waddr[i] = '0;
        end
        @(posedge clk); #1;
        start = 1'b1; cfg_kij = kij_v; cfg_onij = onij_v;
        for (int c = 1; c < 300; c++) begin
            @(posedge clk); #1;
            start    = (c == extra_start);
            cfg_kij  = 4'hF;
            cfg_onij = 5'h1F;
            stall    = (c >= stall_from && c <= stall_to);
            reset    = (c == reset_at);
            @(negedge clk);
            log_rd[c] = psum_rd_en;  log_acc[c] = acc_en;   log_clr[c] = acc_clr;
            log_wr[c] = out_wr_en;   log_done[c] = done;    log_busy[c] = busy;
            log_addr[c] = psum_rd_addr; log_waddr[c] = out_wr_addr;
            if (acc_en !== prev_rd) err_lag++;
            prev_rd = psum_rd_en;
            if (acc_clr && acc_en) err_ovl++;
            if (acc_clr) begin grp++; rix = 0; n_clr++; end
            if (psum_rd_en) begin
                exp_addr = 11'((rix * int'(onij_v)) + grp - 1);
                if (psum_rd_addr !== exp_addr) err_addr++;
                rix++; n_rd++;
            end
            if (acc_en) n_acc++;
            if (out_wr_en) begin
                if (out_wr_addr !== 5'(n_wr)) err_wr++;
                n_wr++;
            end
            if (done) begin
                done_cyc = c;
`ifdef SFP_CTRL_PERF_EN
                perf_at_done = perf_cycles;
`endif
                break;
            end
            if (reset_at > 0 && c == reset_at + 8) break;
        end
        start = 1'b0; stall = 1'b0; reset = 1'b0; cfg_kij = '0; cfg_onij = '0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; cfg_kij = '0; cfg_onij = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", {busy, done, psum_rd_en, acc_clr, acc_en, out_wr_en}, 32'd0);
        check("reset_addrs", {psum_rd_addr, out_wr_addr}, 32'd0);

        // Nominal 9x16 pass with a stray start at cycle 50.
        run_pass(4'd9, 5'd16, -1, -2, 50, -1);
        check("nom_done_cycle", done_cyc, 209);
        check("nom_rd_count", n_rd, 144);
        check("nom_acc_count", n_acc, 144);
        check("nom_clr_count", n_clr, 16);
        check("nom_wr_count", n_wr, 16);
        check("nom_rd_addrs", err_addr, 0);
        check("nom_o3_first_addr", log_addr[41], 3);
        check("nom_o3_last_addr", log_addr[49], 131);
        check("nom_wr_order", err_wr, 0);
        check("nom_acc_lag", err_lag, 0);
        check("nom_clr_overlap", err_ovl, 0);
        check("nom_busy_c1", log_busy[1], 1);
        check("nom_busy_done", log_busy[209], 0);
`ifdef SFP_CTRL_PERF_EN
        check("perf_cycles", perf_at_done, 208);
`endif

        // Minimal pass: CLR, READ 0, FLUSH, DRAIN, WRITE 0, DONE.
        run_pass(4'd1, 5'd1, -1, -2, -1, -1);
        check("min_done_cycle", done_cyc, 6);
        check("min_clr_c1", {log_clr[1], log_rd[1]}, 32'b10);
        check("min_rd_c2", {log_rd[2], log_addr[2]}, {1'b1, 11'd0});
        check("min_acc_c3", {log_acc[3], log_rd[3]}, 32'b10);
        check("min_drain_c4", {log_acc[4], log_wr[4]}, 32'b00);
        check("min_wr_c5", {log_wr[5], log_waddr[5]}, {1'b1, 5'd0});

        // Stall sampled at cycles 31..33 parks the o=2,k=4 read (addr 66).
        run_pass(4'd9, 5'd16, 31, 33, -1, -1);
        check("stall_done_cycle", done_cyc, 212);
        check("stall_rd_count", n_rd, 144);
        check("stall_acc_count", n_acc, 144);
        check("stall_rd_addrs", err_addr, 0);
        check("stall_pre_read", {log_rd[31], log_addr[31]}, {1'b1, 11'd50});
        check("stall_hold_c32", {log_rd[32], log_addr[32]}, {1'b0, 11'd66});
        check("stall_hold_c34", {log_rd[34], log_addr[34], log_clr[34], log_wr[34]}, {1'b0, 11'd66, 2'b00});
        check("stall_reissue", {log_rd[35], log_addr[35]}, {1'b1, 11'd66});
        check("stall_acc_gap", {log_acc[32], log_acc[33], log_acc[34], log_acc[35], log_acc[36]}, 32'b10001);
        check("stall_busy_held", log_busy[33], 1);

        // Zero configuration values finish immediately with no strobes.
        run_pass(4'd0, 5'd16, -1, -2, -1, -1);
        check("zk_done_cycle", done_cyc, 1);
        check("zk_strobes", n_rd + n_clr + n_wr, 0);
        run_pass(4'd9, 5'd0, -1, -2, -1, -1);
        check("zo_done_cycle", done_cyc, 1);
        check("zo_strobes", n_rd + n_clr + n_wr, 0);

        // Reset during the o=5 READ run (cycle 70 reads k=3, addr 53).
        run_pass(4'd9, 5'd16, -1, -2, -1, 70);
        check("rst_mid_read", {log_rd[70], log_addr[70]}, {1'b1, 11'd53});
        check("rst_outputs", {log_busy[71], log_done[71], log_rd[71], log_clr[71], log_acc[71], log_wr[71]}, 32'd0);
        check("rst_addrs", {log_addr[71], log_waddr[71]}, 32'd0);
        check("rst_no_done", done_cyc, 32'hFFFF_FFFF);

        run_pass(4'd2, 5'd3, -1, -2, -1, -1);
        check("post_rst_done", done_cyc, 19);
        check("post_rst_counts", {8'(n_rd), 8'(n_acc), 8'(n_clr), 8'(n_wr)}, {8'd6, 8'd6, 8'd3, 8'd3});
        check("post_rst_addrs", err_addr + err_wr + err_lag + err_ovl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
